// File: rtl/regfile_port_arbiter_if.sv
// Port bundle between the regfile arbiter, its two requesters (core, debug) and the register file.
// The slave side is the arbiter; the master side is everything around it.
interface regfile_port_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              core_we;
  logic [ADDR_W-1:0] core_waddr;
  logic [DATA_W-1:0] core_wdata;
  logic [ADDR_W-1:0] core_raddr1, core_raddr2;
  logic [DATA_W-1:0] core_rdata1, core_rdata2;
  logic              core_stall;

  logic              dbg_req;
  logic              dbg_wr;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic [DATA_W-1:0] dbg_rdata;

  logic              init_done;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_w_addr;
  logic [DATA_W-1:0] rf_w_data;
  logic [ADDR_W-1:0] rf_r_addr1, rf_r_addr2;
  logic [DATA_W-1:0] rf_r_data1, rf_r_data2;

  modport slave (
    input  core_we, core_waddr, core_wdata, core_raddr1, core_raddr2,
    output core_rdata1, core_rdata2, core_stall,
    input  dbg_req, dbg_wr, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata, init_done,
    output rf_we, rf_w_addr, rf_w_data, rf_r_addr1, rf_r_addr2,
    input  rf_r_data1, rf_r_data2
  );

  modport master (
    output core_we, core_waddr, core_wdata, core_raddr1, core_raddr2,
    input  core_rdata1, core_rdata2, core_stall,
    output dbg_req, dbg_wr, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata, init_done,
    input  rf_we, rf_w_addr, rf_w_data, rf_r_addr1, rf_r_addr2,
    output rf_r_data1, rf_r_data2
  );
endinterface

// File: rtl/regfile_port_arbiter.sv
// Clears r1..r(NREGS-1) after reset, then shares the register file between the core
// (priority) and a debug port whose writes are deferred at most MAX_WAIT cycles.
module regfile_port_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_port_arbiter_if.slave bus
);
  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0]     WAIT_LIM = WW'(MAX_WAIT);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(NREGS - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [WW-1:0]     wait_cnt;
  logic              ack_q, init_done_q;
  logic [DATA_W-1:0] dbg_rdata_q;
  logic              elig, serve_rd, serve_wr, defer;

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == INIT && cnt == LAST) state_nxt = RUN;
  end

  // The ack cycle blocks eligibility, so back-to-back services are at least 2 cycles apart.
  always_comb begin
    elig     = (state == RUN) && bus.dbg_req && !ack_q;
    serve_rd = elig && !bus.dbg_wr;
    serve_wr = elig && bus.dbg_wr && (!bus.core_we || wait_cnt == WAIT_LIM);
    defer    = elig && bus.dbg_wr && bus.core_we && wait_cnt != WAIT_LIM;
  end

  always_comb begin
    bus.rf_we      = 1'b0;
    bus.rf_w_addr  = bus.core_waddr;
    bus.rf_w_data  = bus.core_wdata;
    bus.rf_r_addr1 = bus.core_raddr1;
    bus.rf_r_addr2 = bus.core_raddr2;
    bus.core_stall = 1'b1;
    if (!rst) begin
      case (state)
        INIT: begin
          bus.rf_we     = 1'b1;
          bus.rf_w_addr = cnt;
          bus.rf_w_data = '0;
        end
        default: begin
          // A read borrows port 1; a starved write takes the write port. Either stalls the core.
          bus.core_stall = serve_rd || (serve_wr && bus.core_we);
          if (serve_wr) begin
            bus.rf_we     = 1'b1;
            bus.rf_w_addr = bus.dbg_addr;
            bus.rf_w_data = bus.dbg_wdata;
          end else begin
            bus.rf_we = bus.core_we && !serve_rd;
          end
          if (serve_rd) bus.rf_r_addr1 = bus.dbg_addr;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= ADDR_W'(1);
      wait_cnt    <= '0;
      ack_q       <= 1'b0;
      init_done_q <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      if (state == INIT) begin
        cnt <= cnt + 1'b1;
        if (cnt == LAST) init_done_q <= 1'b1;
      end
      ack_q <= serve_rd || serve_wr;
      if (serve_rd || serve_wr) wait_cnt <= '0;
      else if (defer)           wait_cnt <= wait_cnt + 1'b1;
      if (serve_rd) dbg_rdata_q <= (bus.dbg_addr == '0) ? '0 : bus.rf_r_data1;
    end
  end

  assign bus.core_rdata1 = bus.rf_r_data1;
  assign bus.core_rdata2 = bus.rf_r_data2;
  assign bus.dbg_ack     = ack_q;
  assign bus.dbg_rdata   = dbg_rdata_q;
  assign bus.init_done   = init_done_q;
endmodule

// File: doc/regfile_port_arbiter.md
# regfile_port_arbiter

Sequencer and arbiter in front of the 32×32 register file (two combinational read ports, one clocked write port). After reset it clears r1..r31 to zero. It then shares the register file between the core datapath and a debug/host access port. The core has priority, and a bounded-wait rule guarantees debug progress.

## Interface
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- NREGS, 32, number of registers (r0 hardwired zero in the register file)
- MAX_WAIT, 3, cycles a pending debug write may be deferred by core writes before the core is stalled

- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- core_we  in  1  core write request
- core_waddr  in  ADDR_W  core write address
- core_wdata  in  DATA_W  core write data
- core_raddr1, core_raddr2  in  ADDR_W  core read addresses
- core_rdata1, core_rdata2  out  DATA_W  core read data (pass-through of rf_r_data1/2)
- core_stall  out  1  core must hold all inputs; its write is not performed this cycle
- dbg_req  in  1  debug request, held until dbg_ack
- dbg_wr  in  1  1 = write, 0 = read
- dbg_addr  in  ADDR_W  debug register address
- dbg_wdata  in  DATA_W  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  DATA_W  debug read result, valid while dbg_ack=1 and held until next read
- init_done  out  1  clear sequence finished
- rf_we  out  1  register file write enable
- rf_w_addr  out  ADDR_W  register file write address
- rf_w_data  out  DATA_W  register file write data
- rf_r_addr1, rf_r_addr2  out  ADDR_W  register file read addresses
- rf_r_data1, rf_r_data2  in  DATA_W  register file read data

## Operation
- States: INIT, RUN. Registered `cnt` (ADDR_W), `wait_cnt`, `ack_q`.
- **rst**
  - Force state=INIT, cnt=1, wait_cnt=0.
  - dbg_ack=0, dbg_rdata=0, init_done=0.
  - While rst is high, rf_we=0 and core_stall=1.
- **INIT**
  - rf_we=1, rf_w_addr=cnt, rf_w_data=0, core_stall=1.
  - cnt increments each cycle.
  - After the write with cnt=NREGS-1, go to RUN and set init_done=1, which stays 1 until rst.
  - dbg_req is ignored in INIT and stays pending.
- **RUN default (no debug service this cycle)**
  - rf_we=core_we, rf_w_addr=core_waddr, rf_w_data=core_wdata.
  - rf_r_addr1/2 = core_raddr1/2.
  - core_stall=0.
- **Debug eligibility:** dbg_req=1 and ack_q=0. The ack cycle never starts a new service.
- **Debug write**
  - If core_we=0: serve this cycle with no stall. rf_we=1, rf_w_addr=dbg_addr, rf_w_data=dbg_wdata.
  - If core_we=1: the core write wins and wait_cnt increments.
  - When wait_cnt==MAX_WAIT: serve the debug write, assert core_stall=1, and suppress the core write.
  - wait_cnt clears on every debug service.
- **Debug read**
  - Served in the first eligible cycle.
  - rf_r_addr1=dbg_addr and core_stall=1, because port 1 is borrowed. Port 2 stays with the core.
  - rf_r_data1 is captured into dbg_rdata on that edge.
  - A core write in the same cycle is suppressed because the core is stalled.
- **Ack:** dbg_ack=1 in the cycle after service, for exactly one cycle.
- **r0**
  - A debug write to r0 is passed through and the register file discards it.
  - A debug read of r0 returns 0.

## Timing
- Clear latency: the first rising edge with rst=0 writes r1. r31 is written on edge 31. init_done=1 from the cycle after the r31 write.
- Read data is combinational through the register file. A write at edge E is visible to any read address from cycle E+1. A same-cycle read returns the old value.
- Debug service: serve in cycle T, dbg_ack in T+1, earliest next service in T+2.
- Maximum debug write latency from first eligible cycle to service: MAX_WAIT+1 cycles.
- Each debug read stalls the core exactly 1 cycle. A starved debug write stalls it exactly 1 cycle. Otherwise core_stall=0 in RUN.
- rst mid-INIT restarts the clear at r1.
- rst with a debug request pending or being acked drops it: no dbg_ack, wait_cnt=0.

## Test plan
- **Reset and clear:** pulse rst 2 cycles, then release.
  - rf_we=1 with addr 1..31 and data 0 for 31 cycles.
  - init_done rises on cycle 32 and core_stall falls.
  - Core reads of r5 and r31 return 0.
- **Core write and dual read:** core writes r5=AAAA5555 and r10=DEADBEEF.
  - Next cycles: core_raddr1=5, core_raddr2=10 give AAAA5555 and DEADBEEF simultaneously.
  - core_stall stays 0 throughout.
- **Debug write, core idle:** dbg write r7=12345678 with core_we=0.
  - Written the same cycle, dbg_ack the next cycle, no stall.
  - Core read of r7 = 12345678.
- **Starvation:** core_we=1 every cycle writing r3=00000001, dbg write r3=FFFFFFFF, MAX_WAIT=3.
  - 3 core writes are performed, then 1 stall cycle performs the debug write.
  - Ack follows, and the core write resumes after the stall.
- **Debug read:** dbg read r5 while the core reads r10 on port 2.
  - core_stall=1 for one cycle and core_rdata2 stays DEADBEEF.
  - Next cycle: dbg_ack=1 with dbg_rdata=AAAA5555.
  - A debug write of 1234ABCD to r0 followed by a debug read of r0 returns 0.
- **Reset mid-operation:**
  - rst during INIT at cnt=10 restarts the clear at r1.
  - rst during the serve cycle of a debug read produces no dbg_ack, and dbg_rdata=0.
